weight_update_engine: RTL and testbench

WEIGHT_UPDATE_ENGINE -- requirements
Module: weight_update_engine

---
 rtl/weight_update_engine.sv | 137 +++++++++++++
 tb/tb_weight_update_engine.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_engine.sv
// Output-layer training step: computes one delta per output neuron, then
// read-modify-writes every output weight through a single-port weight memory.
module weight_update_engine #(
   parameter int N_OUT    = 3,
   parameter int N_HID    = 5,
   parameter int W        = 10,
   parameter int FRAC     = 8,
   parameter int LR_SHIFT = 2,
   parameter int AW       = 7,
   parameter int BASE     = 50
) (
   input  logic                    Clock,
   input  logic                    Rst,
   input  logic                    start,
   input  logic [N_OUT*W-1:0]      actual_bus,
   input  logic [N_OUT*W-1:0]      cal_bus,
   input  logic [N_HID*W-1:0]      hid_bus,
   output logic                    busy,
   output logic                    done,
   output logic [N_OUT*W-1:0]      delta_bus,
   output logic [AW-1:0]           mem_addr,
   input  logic signed [W-1:0]     mem_rdata,
   output logic                    mem_we,
   output logic signed [W-1:0]     mem_wdata
);

   // Wide enough that no intermediate product or sum can wrap before saturation.
   localparam int PW = 3*W + 4;
   localparam int JW = $clog2(N_OUT + 1);
   localparam int IW = $clog2(N_HID + 1);
   localparam logic signed [PW-1:0] ONE  = PW'(2**FRAC);
   localparam logic signed [PW-1:0] SMAX = PW'(2**(W-1) - 1);
   localparam logic signed [PW-1:0] SMIN = ~SMAX;

   typedef enum logic [2:0] {IDLE, DELTA, RD, WR, DONE} state_t;

   state_t               state_reg;
   logic [N_OUT*W-1:0]   actual_reg;
   logic [N_OUT*W-1:0]   cal_reg;
   logic [N_HID*W-1:0]   hid_reg;
   logic [JW-1:0]        j_reg;
   logic [IW-1:0]        i_reg;

   logic signed [PW-1:0] act_x, cal_x, err_x, sp_x, delta_x;
   logic signed [PW-1:0] dsel_x, hid_x, dw_x, sum_x;

   function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] v);
      if (v > SMAX) return SMAX[W-1:0];
      if (v < SMIN) return SMIN[W-1:0];
      return v[W-1:0];
   endfunction

   always_comb begin
      act_x   = signed'(PW'(actual_reg[j_reg*W +: W]));
      cal_x   = signed'(PW'(cal_reg[j_reg*W +: W]));
      err_x   = act_x - cal_x;
      sp_x    = (cal_x * (ONE - cal_x)) >>> FRAC;
      delta_x = (err_x * sp_x) >>> FRAC;
      dsel_x  = PW'(signed'(delta_bus[j_reg*W +: W]));
      hid_x   = signed'(PW'(hid_reg[i_reg*W +: W]));
      dw_x    = (dsel_x * hid_x) >>> (FRAC + LR_SHIFT);
      sum_x   = PW'(mem_rdata) + dw_x;
   end

   // Write data only meaningful while the strobe is up; held at zero otherwise.
   assign mem_wdata = mem_we ? sat(sum_x) : '0;

   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state_reg  <= IDLE;
         actual_reg <= '0;
         cal_reg    <= '0;
         hid_reg    <= '0;
         j_reg      <= '0;
         i_reg      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         delta_bus  <= '0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  actual_reg <= actual_bus;
                  cal_reg    <= cal_bus;
                  hid_reg    <= hid_bus;
                  j_reg      <= '0;
                  i_reg      <= '0;
                  busy       <= 1'b1;
                  state_reg  <= DELTA;
               end
            end
            DELTA: begin
               delta_bus[j_reg*W +: W] <= sat(delta_x);
               if (j_reg == JW'(N_OUT - 1)) begin
                  j_reg     <= '0;
                  i_reg     <= '0;
                  mem_addr  <= AW'(BASE);
                  state_reg <= RD;
               end else begin
                  j_reg <= j_reg + 1'b1;
               end
            end
            RD: begin
               mem_we    <= 1'b1;
               state_reg <= WR;
            end
            WR: begin
               // Weights of neuron j are contiguous, so the next address is always +1.
               mem_addr <= mem_addr + 1'b1;
               if (i_reg == IW'(N_HID - 1)) begin
                  i_reg <= '0;
                  if (j_reg == JW'(N_OUT - 1)) begin
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     j_reg     <= j_reg + 1'b1;
                     state_reg <= RD;
                  end
               end else begin
                  i_reg     <= i_reg + 1'b1;
                  state_reg <= RD;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_update_engine.sv
// Randomized bench for weight_update_engine: arithmetic reference model of the
// delta and weight-update rules, scoreboard of memory writes, two configurations.
module tb_weight_update_engine;

   localparam int W    = 10;
   localparam int FRAC = 8;
   localparam int LR   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int checks = 0;
   int failures = 0;

   // default configuration: N_OUT=3, N_HID=5, BASE=50
   logic              start_a, busy_a, done_a, we_a, load_a;
   logic [29:0]       act_bus_a, cal_bus_a, delta_a;
   logic [49:0]       hid_bus_a;
   logic [6:0]        addr_a;
   logic signed [9:0] rdata_a, wdata_a;
   logic signed [9:0] mem_a [0:127];
   int                init_a [0:127];
   int                wq_a_addr [$];
   int                wq_a_data [$];

   // small configuration: N_OUT=2, N_HID=4, BASE=0
   logic              start_b, busy_b, done_b, we_b, load_b;
   logic [19:0]       act_bus_b, cal_bus_b, delta_b;
   logic [39:0]       hid_bus_b;
   logic [6:0]        addr_b;
   logic signed [9:0] rdata_b, wdata_b;
   logic signed [9:0] mem_b [0:127];
   int                init_b [0:127];
   int                wq_b_addr [$];
   int                wq_b_data [$];

   int act_v [0:4];
   int cal_v [0:4];
   int hid_v [0:4];
   int snap  [0:127];
   int exp_d [0:4];
   int exp_addr [$];
   int exp_data [$];

   weight_update_engine dut_a (
      .Clock(clk), .Rst(rst), .start(start_a),
      .actual_bus(act_bus_a), .cal_bus(cal_bus_a), .hid_bus(hid_bus_a),
      .busy(busy_a), .done(done_a), .delta_bus(delta_a),
      .mem_addr(addr_a), .mem_rdata(rdata_a), .mem_we(we_a), .mem_wdata(wdata_a)
   );

   weight_update_engine #(.N_OUT(2), .N_HID(4), .BASE(0)) dut_b (
      .Clock(clk), .Rst(rst), .start(start_b),
      .actual_bus(act_bus_b), .cal_bus(cal_bus_b), .hid_bus(hid_bus_b),
      .busy(busy_b), .done(done_b), .delta_bus(delta_b),
      .mem_addr(addr_b), .mem_rdata(rdata_b), .mem_we(we_b), .mem_wdata(wdata_b)
   );

   // weight memories: registered read, write on strobe, every write logged
   always @(posedge clk) begin
      rdata_a <= mem_a[addr_a];
      if (load_a) begin
         for (int k = 0; k < 128; k++) mem_a[k] <= 10'(init_a[k]);
      end else if (we_a) begin
         mem_a[addr_a] <= wdata_a;
         wq_a_addr.push_back(int'(addr_a));
         wq_a_data.push_back(int'(wdata_a));
      end
   end

   always @(posedge clk) begin
      rdata_b <= mem_b[addr_b];
      if (load_b) begin
         for (int k = 0; k < 128; k++) mem_b[k] <= 10'(init_b[k]);
      end else if (we_b) begin
         mem_b[addr_b] <= wdata_b;
         wq_b_addr.push_back(int'(addr_b));
         wq_b_data.push_back(int'(wdata_b));
      end
   end

   task automatic check_val(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // floor(a / 2^sh), i.e. rounding toward minus infinity
   function automatic int fdiv(input int a, input int sh);
      int d;
      int q;
      d = 1 << sh;
      q = a / d;
      if ((a % d) != 0 && a < 0) q -= 1;
      return q;
   endfunction

   function automatic int sat10(input int v);
      if (v > 511) return 511;
      if (v < -512) return -512;
      return v;
   endfunction

   task automatic build_model(input int n_out, input int n_hid, input int base);
      int sp;
      int a;
      exp_addr.delete();
      exp_data.delete();
      for (int j = 0; j < n_out; j++) begin
         sp = fdiv(cal_v[j] * (256 - cal_v[j]), FRAC);
         exp_d[j] = sat10(fdiv((act_v[j] - cal_v[j]) * sp, FRAC));
      end
      for (int j = 0; j < n_out; j++)
         for (int i = 0; i < n_hid; i++) begin
            a = base + j*n_hid + i;
            exp_addr.push_back(a);
            exp_data.push_back(sat10(snap[a] + fdiv(exp_d[j] * hid_v[i], FRAC + LR)));
         end
   endtask

   task automatic load_mems();
      load_a = 1'b1;
      load_b = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
   endtask

   task automatic random_stim();
      for (int j = 0; j < 5; j++) begin
         act_v[j] = int'($urandom_range(0, 1023));
         cal_v[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                                : int'($urandom_range(0, 300));
         hid_v[j] = int'($urandom_range(0, 1023));
      end
   endtask

   task automatic random_mem();
      for (int k = 0; k < 128; k++) begin
         init_a[k] = int'($urandom_range(0, 1023)) - 512;
         init_b[k] = int'($urandom_range(0, 1023)) - 512;
      end
   endtask

   // mode: 0 plain, 1 extra start at cycle 10, 2 start during done, 3 reset at cycle 20
   task automatic run_a(input int mode);
      int  k;
      int  lat;
      int  nw;
      bit  aborted;
      for (int a = 0; a < 128; a++) snap[a] = int'(mem_a[a]);
      build_model(3, 5, 50);
      wq_a_addr.delete();
      wq_a_data.delete();
      for (int j = 0; j < 3; j++) begin
         act_bus_a[j*W +: W] = 10'(act_v[j]);
         cal_bus_a[j*W +: W] = 10'(cal_v[j]);
      end
      for (int i = 0; i < 5; i++) hid_bus_a[i*W +: W] = 10'(hid_v[i]);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check_val("busy_after_start", longint'(busy_a), 1);
      k = 1;
      lat = -1;
      aborted = 1'b0;
      while (k <= 200 && lat < 0 && !aborted) begin
         if (done_a) begin
            lat = k;
         end else if (mode == 3 && k == 20) begin
            rst = 1'b1;
            #1;
            check_val("rst_busy", longint'(busy_a), 0);
            check_val("rst_we", longint'(we_a), 0);
            check_val("rst_delta", longint'(delta_a), 0);
            check_val("rst_done", longint'(done_a), 0);
            nw = wq_a_addr.size();
            check_val("writes_before_rst", nw, 8);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            check_val("no_writes_after_rst", wq_a_addr.size(), nw);
            aborted = 1'b1;
         end else begin
            act_bus_a = 30'($urandom());
            cal_bus_a = 30'($urandom());
            hid_bus_a = 50'({$urandom(), $urandom()});
            start_a   = (mode == 1 && k == 10);
            @(negedge clk);
            k++;
         end
      end
      start_a = 1'b0;
      nw = wq_a_addr.size();
      if (!aborted) begin
         check_val("latency", lat, 34);
         check_val("busy_at_done", longint'(busy_a), 0);
         if (mode == 2) start_a = 1'b1;
         @(negedge clk);
         start_a = 1'b0;
         check_val("done_one_cycle", longint'(done_a), 0);
         check_val("idle_after_done", longint'(busy_a), 0);
         check_val("write_count", nw, exp_addr.size());
         for (int j = 0; j < 3; j++)
            check_val($sformatf("delta%0d", j), longint'($signed(delta_a[j*W +: W])), exp_d[j]);
      end
      for (int n = 0; n < nw && n < exp_addr.size(); n++) begin
         check_val($sformatf("waddr%0d", n), wq_a_addr[n], exp_addr[n]);
         check_val($sformatf("wdata%0d", n), wq_a_data[n], exp_data[n]);
      end
      $display("update A mode=%0d latency=%0d writes=%0d delta=%0d,%0d,%0d", mode, lat, nw,
               exp_d[0], exp_d[1], exp_d[2]);
   endtask

   task automatic run_b();
      int k;
      int lat;
      for (int a = 0; a < 128; a++) snap[a] = int'(mem_b[a]);
      build_model(2, 4, 0);
      wq_b_addr.delete();
      wq_b_data.delete();
      for (int j = 0; j < 2; j++) begin
         act_bus_b[j*W +: W] = 10'(act_v[j]);
         cal_bus_b[j*W +: W] = 10'(cal_v[j]);
      end
      for (int i = 0; i < 4; i++) hid_bus_b[i*W +: W] = 10'(hid_v[i]);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      k = 1;
      lat = -1;
      while (k <= 100 && lat < 0) begin
         if (done_b) lat = k;
         else begin
            @(negedge clk);
            k++;
         end
      end
      check_val("b_latency", lat, 19);
      check_val("b_write_count", wq_b_addr.size(), 8);
      for (int j = 0; j < 2; j++)
         check_val($sformatf("b_delta%0d", j), longint'($signed(delta_b[j*W +: W])), exp_d[j]);
      for (int n = 0; n < wq_b_addr.size() && n < exp_addr.size(); n++) begin
         check_val($sformatf("b_waddr%0d", n), wq_b_addr[n], exp_addr[n]);
         check_val($sformatf("b_wdata%0d", n), wq_b_data[n], exp_data[n]);
      end
      $display("update B latency=%0d writes=%0d", lat, wq_b_addr.size());
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      load_a = 1'b0; load_b = 1'b0;
      act_bus_a = '0; cal_bus_a = '0; hid_bus_a = '0;
      act_bus_b = '0; cal_bus_b = '0; hid_bus_b = '0;
      repeat (3) @(negedge clk);
      check_val("reset_busy", longint'(busy_a), 0);
      check_val("reset_done", longint'(done_a), 0);
      check_val("reset_we", longint'(we_a), 0);
      check_val("reset_addr", longint'(addr_a), 0);
      check_val("reset_wdata", longint'(wdata_a), 0);
      check_val("reset_delta", longint'(delta_a), 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_reset_busy", longint'(busy_a), 0);

      // nominal: every delta 32, weights 100 -> 108
      for (int k = 0; k < 128; k++) init_a[k] = 100;
      for (int k = 0; k < 128; k++) init_b[k] = 0;
      load_mems();
      for (int j = 0; j < 5; j++) begin
         act_v[j] = 256; cal_v[j] = 128; hid_v[j] = 256;
      end
      run_a(0);
      check_val("mem50", longint'(mem_a[50]), 108);
      check_val("mem64", longint'(mem_a[64]), 108);
      check_val("mem65_untouched", longint'(mem_a[65]), 100);

      // zero error: weights rewritten unchanged, extra start during done ignored
      random_mem();
      load_mems();
      random_stim();
      for (int j = 0; j < 5; j++) begin
         act_v[j] = 200; cal_v[j] = 200;
      end
      run_a(2);

      // saturation at both rails
      random_mem();
      for (int i = 0; i < 5; i++) begin
         init_a[50 + i] = 511;
         init_a[55 + i] = -512;
      end
      load_mems();
      random_stim();
      act_v[0] = 256; cal_v[0] = 128;
      act_v[1] = 0;   cal_v[1] = 128;
      for (int i = 0; i < 5; i++) hid_v[i] = 256;
      run_a(0);
      check_val("sat_hi", longint'(mem_a[52]), 511);
      check_val("sat_lo", longint'(mem_a[57]), -512);

      // start re-pulsed mid-update
      random_mem();
      load_mems();
      random_stim();
      run_a(1);

      // reset mid-update, then a full update from the partially written memory
      random_stim();
      run_a(3);
      random_stim();
      run_a(0);

      for (int t = 0; t < 4; t++) begin
         random_mem();
         load_mems();
         random_stim();
         run_a(0);
      end

      // small configuration
      for (int t = 0; t < 2; t++) begin
         random_mem();
         load_mems();
         random_stim();
         run_b();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
